button_conditioner: RTL and testbench

//  Conditions a raw board push-button for the traffic-light state sequencer that drives its next-state input.

---
 rtl/btn_pkg.sv | 16 +
 rtl/sync_2ff.sv | 23 ++
 rtl/button_conditioner.sv | 116 +++++++++++
 tb/tb_button_conditioner.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button conditioner.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    LONG,
    RELEASE_WAIT
  } btn_state_t;

  // Defaults for the 50 MHz main clock: 20 ms debounce, 1 s long press.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 1000000;
  localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 50000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous board input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Synchronises and debounces a raw push-button; emits a clean level plus
// one-cycle press, release and long-press pulses.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter bit          BTN_ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  btn_state_t        state;
  logic [DEB_W-1:0]  deb_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              long_fired;
  logic              btn_sync;
  logic              act;

  // Flops reset to the released pin level so reset never looks like a press.
  sync_2ff #(
    .RESET_VAL (BTN_ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (btn_sync)
  );

  assign act = btn_sync ^ BTN_ACTIVE_LOW;

  // Debounce FSM; pulses default low so each fires for exactly one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      deb_cnt          <= '0;
      hold_cnt         <= '0;
      long_fired       <= 1'b0;
      btn_level        <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
    end else begin
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (act) begin
            state   <= PRESS_WAIT;
            deb_cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!act) begin
            state   <= IDLE;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state       <= PRESSED;
            hold_cnt    <= '0;
            press_pulse <= 1'b1;
            btn_level   <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end
        PRESSED: begin
          // Release wins over a long-press landing in the same cycle.
          if (!act) begin
            state   <= RELEASE_WAIT;
            deb_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state            <= LONG;
            long_press_pulse <= 1'b1;
            long_fired       <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        LONG: begin
          if (!act) begin
            state   <= RELEASE_WAIT;
            deb_cnt <= '0;
          end
        end
        RELEASE_WAIT: begin
          // A bounce back returns to where we were; hold_cnt stays frozen.
          if (act) begin
            state   <= long_fired ? LONG : PRESSED;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            long_fired    <= 1'b0;
            btn_level     <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bouncing,
// both polarities checked every cycle against a run-length reference model.
module tb_button_conditioner;

  localparam int unsigned D = 4;
  localparam int unsigned L = 10;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic btn_raw = 1'b1;
  logic btn_raw_h;
  assign btn_raw_h = ~btn_raw;

  logic lvl_l, prs_l, rel_l, lng_l;
  logic lvl_h, prs_h, rel_h, lng_h;

  button_conditioner #(
    .DEBOUNCE_CYCLES (D), .LONG_PRESS_CYCLES (L), .BTN_ACTIVE_LOW (1'b1)
  ) dut_l (
    .clk (clk), .reset (reset), .btn_raw (btn_raw),
    .btn_level (lvl_l), .press_pulse (prs_l),
    .release_pulse (rel_l), .long_press_pulse (lng_l)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES (D), .LONG_PRESS_CYCLES (L), .BTN_ACTIVE_LOW (1'b0)
  ) dut_h (
    .clk (clk), .reset (reset), .btn_raw (btn_raw_h),
    .btn_level (lvl_h), .press_pulse (prs_h),
    .release_pulse (rel_h), .long_press_pulse (lng_h)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int press_cnt = 0, rel_cnt = 0, long_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model: the level flips once D+1 consecutive sampled values
  // disagree with it; a long press fires after L steady pressed samples.
  logic m_p1 = 1'b0, m_p2 = 1'b0, m_level = 1'b0, m_fired = 1'b0, m_a = 1'b0;
  int   m_run = 0, m_held = 0;
  logic e_level = 1'b0, e_press = 1'b0, e_rel = 1'b0, e_long = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_p1 = 1'b0; m_p2 = 1'b0; m_level = 1'b0; m_fired = 1'b0;
        m_run = 0; m_held = 0;
        e_level = 1'b0; e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
      end else begin
        m_a  = m_p2;
        m_p2 = m_p1;
        m_p1 = !btn_raw;
        e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
        if (m_a != m_level) begin
          m_run++;
          if (m_run == D + 1) begin
            m_level = m_a;
            m_run   = 0;
            if (m_a) begin e_press = 1'b1; m_held = 0; end
            else begin e_rel = 1'b1; m_fired = 1'b0; end
          end
        end else begin
          if (m_run == 0 && m_a && !m_fired) begin
            if (m_held == L - 1) begin e_long = 1'b1; m_fired = 1'b1; end
            else m_held++;
          end
          m_run = 0;
        end
        e_level = m_level;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("level_l", lvl_l, e_level);
      check("press_l", prs_l, e_press);
      check("release_l", rel_l, e_rel);
      check("long_l", lng_l, e_long);
      check("level_h", lvl_h, e_level);
      check("press_h", prs_h, e_press);
      check("release_h", rel_h, e_rel);
      check("long_h", lng_h, e_long);
      check("one_pulse", ((int'(prs_l) + int'(rel_l) + int'(lng_l)) <= 1), 1);
      press_cnt += int'(prs_l);
      rel_cnt   += int'(rel_l);
      long_cnt  += int'(lng_l);
    end
  end

  task automatic at_edge(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v);
    @(posedge clk);
    #2 btn_raw = v;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    btn_raw = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  int c0;
  int len;

  initial begin
    #1 reset = 1'b0;
    #2;
    check("rst_level", lvl_l, 0);
    check("rst_press", prs_l, 0);
    check("rst_release", rel_l, 0);
    check("rst_long", lng_l, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    // Scenario 1 (and mirrored polarity): press, hold, long press once.
    do_reset();
    drive(1'b0);
    c0 = long_cnt;
    at_edge(6);
    check("s1_press_e6", prs_l, 0);
    check("s1_level_e6", lvl_l, 0);
    at_edge(1);
    check("s1_press_e7", prs_l, 1);
    check("s1_level_e7", lvl_l, 1);
    check("s6_press_e7", prs_h, 1);
    check("s6_level_e7", lvl_h, 1);
    at_edge(9);
    check("s1_long_e16", lng_l, 0);
    at_edge(1);
    check("s1_long_e17", lng_l, 1);
    check("s6_long_e17", lng_h, 1);
    at_edge(13);
    #1 check("s1_long_once", long_cnt - c0, 1);
    drive(1'b1);
    at_edge(6);
    check("s1_release_e6", rel_l, 0);
    at_edge(1);
    check("s1_release_e7", rel_l, 1);
    check("s1_level_fall", lvl_l, 0);

    // Scenario 2: three-cycle glitch is ignored.
    c0 = press_cnt;
    drive(1'b0);
    repeat (3) @(posedge clk);
    #2 btn_raw = 1'b1;
    at_edge(12);
    #1 check("s2_no_press", press_cnt - c0, 0);
    check("s2_level", lvl_l, 0);

    // Scenario 3: release with 2-cycle bounces.
    drive(1'b0);
    at_edge(12);
    check("s3_level_pressed", lvl_l, 1);
    c0 = rel_cnt;
    @(posedge clk);
    #2;
    for (int i = 0; i < 4; i++) begin
      btn_raw = ~btn_raw;
      repeat (2) @(posedge clk);
      #2;
    end
    btn_raw = 1'b1;
    at_edge(6);
    check("s3_release_e6", rel_l, 0);
    check("s3_level_e6", lvl_l, 1);
    at_edge(1);
    check("s3_release_e7", rel_l, 1);
    check("s3_level_e7", lvl_l, 0);
    #1 check("s3_release_once", rel_cnt - c0, 1);

    // Scenario 4: release lands on the long-press cycle.
    do_reset();
    c0 = long_cnt;
    drive(1'b0);
    at_edge(14);
    btn_raw = 1'b1;
    at_edge(6);
    check("s4_release_e6", rel_l, 0);
    at_edge(1);
    check("s4_release_e7", rel_l, 1);
    #1 check("s4_no_long", long_cnt - c0, 0);

    // Scenario 5: reset mid-press, button still held.
    do_reset();
    c0 = rel_cnt;
    drive(1'b0);
    at_edge(10);
    check("s5_level_before", lvl_l, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("s5_rst_level", lvl_l, 0);
    check("s5_rst_level_h", lvl_h, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    at_edge(6);
    check("s5_press_e6", prs_l, 0);
    at_edge(1);
    check("s5_press_e7", prs_l, 1);
    check("s5_level_e7", lvl_l, 1);
    #1 check("s5_no_release", rel_cnt - c0, 0);

    // Random bouncing with occasional resets.
    @(posedge clk);
    #2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #2 reset = 1'b1;
      end else begin
        btn_raw = ~btn_raw;
        len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(12, 25))
                                          : int'($urandom_range(1, 8));
        repeat (len) @(posedge clk);
        #2;
      end
    end
    btn_raw = 1'b1;
    at_edge(12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
